// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Default widths match the 32-entry integer register file.
package regfile_write_arbiter_pkg;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam int REQ_WB  = 0;
  localparam int REQ_LD  = 1;
  localparam int REQ_DBG = 2;

  localparam int DEF_NUM_REQ  = 3;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;

  // Index width that stays legal for a single requester.
  function automatic int idxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around. Emits one-hot grant plus its encoded index.
module rr_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = idxW(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int cand;

  // Walk from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = 0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % N;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among NUM_REQ requesters after an
// init sweep that writes INIT_VALUE to x1..x(NUM_REGS-1).
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int                NUM_REQ    = DEF_NUM_REQ,
  parameter int                NUM_REGS   = DEF_NUM_REGS,
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter int                IDW        = idxW(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        RegWrite,
  output logic [ADDR_W-1:0]           writeReg,
  output logic [DATA_W-1:0]           writeData,
  output logic                        init_done,
  output logic [IDW-1:0]              grant_id
);

  // One extra bit so NUM_REGS == 2**ADDR_W still compares cleanly.
  localparam logic [ADDR_W:0] LAST_REG = (ADDR_W+1)'(NUM_REGS - 1);

  state_t              state, stateNxt;
  logic [ADDR_W:0]     initPtr, initPtrNxt;
  logic [IDW-1:0]      rrPtr, rrPtrNxt;
  logic                regWriteNxt, initDoneNxt;
  logic [ADDR_W-1:0]   writeRegNxt;
  logic [DATA_W-1:0]   writeDataNxt;
  logic [IDW-1:0]      grantIdNxt;

  logic [NUM_REQ-1:0]  grantOh;
  logic [IDW-1:0]      grantIdx;
  logic [ADDR_W-1:0]   selAddr;
  logic [DATA_W-1:0]   selData;

  rr_arbiter #(.N(NUM_REQ), .IW(IDW)) uArb (
    .req   (req_valid),
    .ptr   (rrPtr),
    .grant (grantOh),
    .idx   (grantIdx)
  );

  assign selAddr = req_addr[grantIdx*ADDR_W +: ADDR_W];
  assign selData = req_data[grantIdx*DATA_W +: DATA_W];

  always_comb begin
    stateNxt     = state;
    initPtrNxt   = initPtr;
    rrPtrNxt     = rrPtr;
    regWriteNxt  = 1'b0;
    writeRegNxt  = writeReg;
    writeDataNxt = writeData;
    grantIdNxt   = grant_id;
    initDoneNxt  = init_done;
    req_ready    = '0;
    case (state)
      ST_INIT: begin
        regWriteNxt  = 1'b1;
        writeRegNxt  = initPtr[ADDR_W-1:0];
        writeDataNxt = INIT_VALUE;
        initPtrNxt   = initPtr + 1'b1;
        if (initPtr == LAST_REG) begin
          stateNxt    = ST_RUN;
          initDoneNxt = 1'b1;
        end
      end
      ST_RUN: begin
        // grantOh only ever selects an asserted valid, so ready implies transfer.
        req_ready = grantOh;
        if (|grantOh) begin
          rrPtrNxt = (int'(grantIdx) == NUM_REQ - 1) ? '0 : grantIdx + IDW'(1);
          // x0 writes consume the slot but never reach the file.
          if (selAddr != '0) begin
            regWriteNxt  = 1'b1;
            writeRegNxt  = selAddr;
            writeDataNxt = selData;
            grantIdNxt   = grantIdx;
          end
        end
      end
      default: stateNxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      initPtr   <= (ADDR_W+1)'(1);
      rrPtr     <= '0;
      RegWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      init_done <= 1'b0;
      grant_id  <= '0;
    end else begin
      state     <= stateNxt;
      initPtr   <= initPtrNxt;
      rrPtr     <= rrPtrNxt;
      RegWrite  <= regWriteNxt;
      writeReg  <= writeRegNxt;
      writeData <= writeDataNxt;
      init_done <= initDoneNxt;
      grant_id  <= grantIdNxt;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: init sweep, single and
// contending requests, x0 drop, and reset mid-sweep.
module tb_regfile_write_arbiter;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              RegWrite;
  logic [AW-1:0]     writeReg;
  logic [DW-1:0]     writeData;
  logic              init_done;
  logic [1:0]        grant_id;

  int nChk  = 0;
  int nFail = 0;

  regfile_write_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .RegWrite  (RegWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .init_done (init_done),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic setReq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic chkZero(input string tag);
    chk({tag, ".RegWrite"},  64'(RegWrite),  64'd0);
    chk({tag, ".writeReg"},  64'(writeReg),  64'd0);
    chk({tag, ".writeData"}, 64'(writeData), 64'd0);
    chk({tag, ".init_done"}, 64'(init_done), 64'd0);
    chk({tag, ".grant_id"},  64'(grant_id),  64'd0);
    chk({tag, ".ready"},     64'(req_ready), 64'd0);
  endtask

  // Step n sweep edges; writes must be x1.. with data 0, ready low.
  task automatic sweep(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s.we%0d", tag, k),   64'(RegWrite), 64'd1);
      chk($sformatf("%s.wr%0d", tag, k),   64'(writeReg), 64'(k));
      chk($sformatf("%s.wd%0d", tag, k),   64'(writeData), 64'd0);
      chk($sformatf("%s.done%0d", tag, k), 64'(init_done), 64'(k == 31));
      if (k < 31) chk($sformatf("%s.rdy%0d", tag, k), 64'(req_ready), 64'd0);
    end
  endtask

  // Present current inputs, check ready, clock once, check registered write.
  task automatic xfer(input string tag, input logic [NR-1:0] expRdy, input logic expWe,
                      input logic [AW-1:0] expReg, input logic [DW-1:0] expData,
                      input logic [1:0] expGid);
    #1;
    chk({tag, ".ready"}, 64'(req_ready), 64'(expRdy));
    @(posedge clk); #1;
    chk({tag, ".we"},  64'(RegWrite),  64'(expWe));
    chk({tag, ".reg"}, 64'(writeReg),  64'(expReg));
    chk({tag, ".dat"}, 64'(writeData), 64'(expData));
    chk({tag, ".gid"}, 64'(grant_id),  64'(expGid));
  endtask

  initial begin
    logic [DW-1:0] rrData [3];
    rrData[0] = 32'hA0A0_0000;
    rrData[1] = 32'hA1A1_1111;
    rrData[2] = 32'hA2A2_2222;

    reset_n   = 1'b0;
    req_valid = '1;
    req_addr  = '0;
    req_data  = '0;
    setReq(0, 5'd1, 32'h1);
    setReq(1, 5'd2, 32'h2);
    setReq(2, 5'd3, 32'h3);
    #1;
    chkZero("rst");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    sweep("init", 31);

    // single requester 1
    req_valid = 3'b010;
    setReq(1, 5'd5, 32'hDEADBEEF);
    xfer("one", 3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1);
    req_valid = '0;
    xfer("idle", 3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 2'd1);

    // x0 write from requester 2: accepted, no file write, pointer wraps to 0
    req_valid = 3'b100;
    setReq(2, 5'd0, 32'h1234);
    xfer("x0", 3'b100, 1'b0, 5'd5, 32'hDEADBEEF, 2'd1);

    // all three contend from pointer 0
    req_valid = 3'b111;
    for (int i = 0; i < 3; i++) setReq(i, AW'(i + 1), rrData[i]);
    for (int c = 0; c < 6; c++) begin
      xfer($sformatf("rr%0d", c), 3'(1 << (c % 3)), 1'b1, AW'(c % 3 + 1),
           rrData[c % 3], 2'(c % 3));
    end

    // req 0 streams; req 1 pops in once and must win the next slot
    req_valid = 3'b001;
    setReq(0, 5'd7, 32'h77);
    xfer("st0", 3'b001, 1'b1, 5'd7, 32'h77, 2'd0);
    req_valid = 3'b011;
    setReq(1, 5'd8, 32'h88);
    xfer("st1", 3'b010, 1'b1, 5'd8, 32'h88, 2'd1);
    req_valid = 3'b001;
    xfer("st2", 3'b001, 1'b1, 5'd7, 32'h77, 2'd0);

    // reset mid-sweep, then full restart
    req_valid = 3'b111;
    reset_n   = 1'b0;
    #1;
    chkZero("rst2");
    @(posedge clk); #1;
    reset_n = 1'b1;
    sweep("part", 10);
    reset_n = 1'b0;
    #1;
    chkZero("rst3");
    @(posedge clk); #1;
    reset_n = 1'b1;
    sweep("redo", 31);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (RegWrite / writeReg / writeData) among NUM_REQ requesters using valid/ready handshakes and round-robin arbitration.
- After reset, sequences an init sweep that writes INIT_VALUE to every architectural register x1..x(NUM_REGS-1) before accepting any request.
- Sits between the writeback/load/debug sources and the register file.

Parameters:
- NUM_REQ, 3, number of write requesters (0 = ALU writeback, 1 = load unit, 2 = debug)
- NUM_REGS, 32, registers in the file
- ADDR_W, 5, register address width
- DATA_W, 32, data width
- INIT_VALUE, 32'h0, value written during the init sweep

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  NUM_REQ*ADDR_W  packed destination register, requester i at bits [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data
- req_ready  out  NUM_REQ  one-hot accept, combinational
- RegWrite  out  1  register file write enable, registered
- writeReg  out  ADDR_W  register file write address, registered
- writeData  out  DATA_W  register file write data, registered
- init_done  out  1  high once the init sweep has completed
- grant_id  out  clog2(NUM_REQ)  requester index of the current RegWrite cycle, registered

Behaviour:
- Reset values (async, reset_n=0): RegWrite=0, writeReg=0, writeData=0, init_done=0, grant_id=0, state=INIT, init_ptr=1, rr_ptr=0. All req_ready are forced to 0 while reset_n=0.
- FSM states: INIT and RUN. There is no other state.
- INIT:
  - Each cycle registers RegWrite=1, writeReg=init_ptr, writeData=INIT_VALUE, then increments init_ptr.
  - When the write of NUM_REGS-1 is registered, state moves to RUN and init_done=1 from the same edge.
  - The sweep takes exactly NUM_REGS-1 cycles after reset release (31 by default). Register x0 is never written.
  - req_ready=0 throughout INIT.
- RUN, arbitration:
  - The grant goes to the first asserted req_valid searching from rr_ptr upward, with wrap-around.
  - req_ready[g]=1 for the granted index only, combinationally in the same cycle. A transfer happens when valid&ready at the edge.
  - After a transfer, rr_ptr = g+1 mod NUM_REQ. With no transfer, rr_ptr holds.
- RUN, write latency: a transfer at edge N produces RegWrite=1, writeReg=addr, writeData=data, grant_id=g for the cycle after edge N. If there is no transfer, RegWrite=0 and writeReg/writeData/grant_id hold their previous values.
- x0 writes: a request with addr=0 is accepted (ready=1) and consumes the grant and advances rr_ptr. RegWrite stays 0 for that slot.
- Requester hold rule: once valid is asserted, addr and data must be held stable until ready. The arbiter does not buffer; at most one write is in flight.
- Simultaneous requests: exactly one grant per cycle. Losers see ready=0 and are served in round-robin order within NUM_REQ cycles. No starvation.
- Reset mid-operation: a reset_n assertion anywhere (including mid-INIT) immediately clears all outputs. After release the sweep restarts from init_ptr=1.
- The init_ptr counter is ADDR_W+1 bits wide so the terminal compare does not wrap when NUM_REGS=2^ADDR_W.

Decomposition:
- Shared package holds:
  - the state encoding (ST_INIT, ST_RUN)
  - requester index constants (REQ_WB=0, REQ_LD=1, REQ_DBG=2)
  - the default widths
- One sub-module, rr_arbiter (parameter N): takes request vector + rr_ptr and outputs a one-hot grant and encoded index, purely combinational. The top level owns the FSM, the pointers and the output registers.

Test Plan:
- Reset then release → RegWrite=1 for 31 consecutive cycles with writeReg 1..31 and writeData=0. init_done rises on the edge of the writeReg=31 write. req_ready=0 throughout, even with all req_valid=1.
- RUN, only req 1 valid, addr=5, data=32'hDEADBEEF → req_ready=3'b010 in the same cycle. Next cycle RegWrite=1, writeReg=5, writeData=DEADBEEF, grant_id=1.
- All three valid continuously with addrs 1/2/3 and rr_ptr=0 → grant order 0,1,2,0,… and writeReg sequence 1,2,3,1,… with one write per cycle.
- Req 2 valid, addr=0, data=32'h1234 → req_ready[2]=1, the next cycle has RegWrite=0, and rr_ptr advances to 0.
- Assert reset_n=0 at sweep cycle 10 (writeReg=10), release → outputs are 0 during reset. The sweep restarts at writeReg=1 and completes 31 writes before init_done=1.
- Req 0 valid continuously while req 1 asserts once → req 1 is granted within 2 cycles (no starvation). Req 0's addr/data are held unchanged until its ready.
